// File: rtl/btn_conditioner.sv
// Button/switch front end: 2-flop synchronizers, per-button debounce FSMs and
// a single-cycle, lowest-index-wins press pulse for the downstream ALU stage.
module btn_conditioner #(
    parameter int SIZE_BTN     = 3,
    parameter int SIZE_COD     = 6,
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [SIZE_BTN-1:0] i_btn_raw,
    input  logic [SIZE_COD-1:0] i_sw_raw,
    output logic [SIZE_BTN-1:0] o_btn,
    output logic [SIZE_COD-1:0] o_sw,
    output logic [SIZE_BTN-1:0] o_btn_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SIZE_BTN-1:0] btn_meta;
    logic [SIZE_BTN-1:0] btn_sync;
    logic [SIZE_COD-1:0] sw_meta;
    logic [SIZE_COD-1:0] sw_sync;
    logic [SIZE_BTN-1:0] press_req;
    logic [SIZE_BTN-1:0] grant;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchronizer stages.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= i_btn_raw;
            btn_sync <= btn_meta;
            sw_meta  <= i_sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    assign o_sw = sw_sync;

    for (genvar i = 0; i < SIZE_BTN; i++) begin : g_btn
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             req;

        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // NOTE: every output of this block gets a default before the case, so no
        // path leaves a value unassigned and no latch is inferred.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            req       = 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync[i]) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync[i]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        req       = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_sync[i]) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes PRESSED without a second request.
                    if (btn_sync[i]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign press_req[i]   = req;
        assign o_btn_level[i] = (state == PRESSED) || (state == RELEASE_WAIT);
    end

    // Isolate the lowest set request; losing requests are dropped, not queued.
    assign grant = press_req & (~press_req + SIZE_BTN'(1));

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_btn <= '0;
        end else begin
            o_btn <= grant;
        end
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter SIZE_BTN, default 3, SHALL set the number of push-buttons conditioned.
REQ-002 Parameter SIZE_COD, default 6, SHALL set the switch-bank width.
REQ-003 Parameter DEBOUNCE_CNT, default 1000000 (10 ms at 100 MHz), SHALL set the number of consecutive stable synchronized cycles required to accept a level change; legal range 2..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 20, SHALL set the debounce counter width.
REQ-005 Port clock, input, 1 bit, SHALL be the single clock; all state updates on the rising edge.
REQ-006 Port i_reset, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-007 Port i_btn_raw, input, SIZE_BTN bits, SHALL carry the asynchronous, bouncing button levels (1 = pressed).
REQ-008 Port i_sw_raw, input, SIZE_COD bits, SHALL carry the asynchronous switch levels.
REQ-009 Port o_btn, output, SIZE_BTN bits, SHALL carry one-cycle, at-most-one-hot press pulses for the downstream ALU register stage.
REQ-010 Port o_sw, output, SIZE_COD bits, SHALL carry the synchronized switch levels.
REQ-011 Port o_btn_level, output, SIZE_BTN bits, SHALL carry the debounced steady level of each button.

Function
REQ-012 Each i_btn_raw bit and each i_sw_raw bit SHALL pass through its own 2-flop synchronizer; "sync" below means the second flop output.
REQ-013 o_sw SHALL equal the synchronizer output: 2-cycle latency, no debounce.
REQ-014 Each button SHALL own an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a CNT_W-bit counter.
REQ-015 IDLE: sync=1 -> PRESS_WAIT with cnt=0; otherwise stay.
REQ-016 PRESS_WAIT: sync=0 -> IDLE with cnt=0; sync=1 and cnt==DEBOUNCE_CNT-1 -> PRESSED and raise the press request; else cnt+1.
REQ-017 PRESSED: sync=0 -> RELEASE_WAIT with cnt=0; otherwise stay.
REQ-018 RELEASE_WAIT: sync=1 -> PRESSED with cnt=0 and no new request; sync=0 and cnt==DEBOUNCE_CNT-1 -> IDLE; else cnt+1.
REQ-019 The counter SHALL never wrap; it is cleared on every state entry.
REQ-020 o_btn_level[i] SHALL be 1 in states PRESSED and RELEASE_WAIT, and 0 in states IDLE and PRESS_WAIT.
REQ-021 Latency: if raw is sampled high at edge 0 and stays high, the o_btn pulse SHALL assert at edge DEBOUNCE_CNT+2 and deassert at the following edge.
REQ-022 o_btn SHALL be registered, high for exactly one cycle per accepted press, and never asserted on release or while a button is held.
REQ-023 Simultaneous press requests in one cycle: only the lowest-index bit SHALL be driven on o_btn; the other requests SHALL be discarded, not queued. Their FSMs still enter PRESSED.
REQ-024 Any bounce (sync toggling) shorter than DEBOUNCE_CNT cycles SHALL produce no pulse and no o_btn_level change.

Reset
REQ-025 While i_reset=0, all synchronizer flops, FSMs (IDLE), counters, o_btn, o_sw and o_btn_level SHALL be 0, asynchronously, regardless of the clock.
REQ-026 Reset asserted mid-debounce SHALL abort it; a button still held after reset release SHALL be re-debounced from IDLE and yield exactly one pulse.

Verification (DEBOUNCE_CNT=4, SIZE_BTN=3, SIZE_COD=6)
REQ-027 Raw btn[0] held high from edge 0 -> o_btn=3'b001 only during the cycle after edge 6, o_btn_level[0]=1 from edge 6.
REQ-028 btn[1] toggled 1,0,1,0 on consecutive cycles, then held low -> o_btn stays 0 and o_btn_level stays 0.
REQ-029 btn[0] and btn[2] raised on the same edge and held -> a single 3'b001 pulse; btn[2] produces no pulse; o_btn_level=3'b101.
REQ-030 Button held 20 cycles, released with 2-cycle bounce, then pressed again and held -> exactly two pulses, none on release.
REQ-031 i_reset pulled low at edge 4 of a btn[1] press while still held, released at edge 8 -> o_btn 0 throughout reset; one 3'b010 pulse 6 edges after the first post-reset sample edge.
REQ-032 i_sw_raw=6'b101101 applied at edge 0 -> o_sw=6'b101101 from edge 1 (2-flop latency), 0 during reset.
